// File: rtl/pool_window_sequencer_if.sv
// Pixel stream into the sequencer and window-ordered element stream out of it.
// The slave modport is the sequencer's view; master is the view of whatever
// drives pixels in and watches elements come out.
interface pool_window_sequencer_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/pool_window_sequencer.sv
// Reorders a row-major 8-bit feature-map stream into 2x2 pooling-window order
// (TL, TR, BL, BR). One even row is buffered on-chip. The bottom-left pixel of
// each window is parked in a hold register while the two buffered top pixels
// are replayed. The bottom-right pixel is then passed straight through.
// Trailing odd columns and a trailing odd row are consumed but never emitted.
module pool_window_sequencer #(
   parameter int MAX_W = 64,
   parameter int CW    = $clog2(MAX_W) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] cfg_width,
   input  logic [CW-1:0] cfg_height,
   pool_window_sequencer_if.slave bus,
   output logic          pool_init,
   output logic          busy,
   output logic          done
);

   localparam int AW = $clog2(MAX_W);

   typedef enum logic [3:0] {
      S_IDLE,
      S_FILL,
      S_PAIR_A,
      S_EMIT0,
      S_EMIT1,
      S_EMIT2,
      S_PAIR_B,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] width_q, width_d;
   logic [CW-1:0] height_q, height_d;
   logic [7:0]    hold_q, hold_d;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          in_ready_q, in_ready_d;
   logic          pool_init_q, pool_init_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [7:0]    row_buf [MAX_W];
   logic [7:0]    rd_data_q;
   logic [AW-1:0] rd_addr;
   logic          wr_en;

   logic          xfer;
   logic          row_end;
   logic [CW-1:0] w_even;
   logic [CW-1:0] h_even;
   logic [CW:0]   col_plus2;
   logic [CW-1:0] row_plus2;

   assign xfer      = bus.in_valid & in_ready_q;
   assign w_even    = {width_q[CW-1:1], 1'b0};
   assign h_even    = {height_q[CW-1:1], 1'b0};
   assign col_plus2 = {1'b0, col_q} + (CW+1)'(2);
   assign row_plus2 = row_q + CW'(2);

   // Next-state, counter and output-register decode.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      width_d     = width_q;
      height_d    = height_q;
      hold_d      = hold_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      pool_init_d = 1'b0;
      done_d      = 1'b0;
      wr_en       = 1'b0;
      rd_addr     = col_q[AW-1:0];
      row_end     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_width < CW'(2) || cfg_height < CW'(2)) begin
                  // Degenerate tile: nothing to pool, just acknowledge.
                  done_d = 1'b1;
               end else begin
                  width_d     = cfg_width;
                  height_d    = cfg_height;
                  col_d       = '0;
                  row_d       = '0;
                  pool_init_d = 1'b1;
                  state_d     = S_FILL;
               end
            end
         end
         S_FILL: begin
            if (xfer) begin
               wr_en = 1'b1;
               if (col_q == width_q - CW'(1)) begin
                  col_d   = '0;
                  state_d = S_PAIR_A;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         S_PAIR_A: begin
            // The RAM read of buf[col] issued here lands in time for EMIT0.
            if (xfer) begin
               if (col_q < w_even) begin
                  hold_d  = bus.in_data;
                  state_d = S_EMIT0;
               end else begin
                  row_end = 1'b1;
               end
            end
         end
         S_EMIT0: begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data_q;
            rd_addr     = col_q[AW-1:0] + AW'(1);
            state_d     = S_EMIT1;
         end
         S_EMIT1: begin
            out_valid_d = 1'b1;
            out_data_d  = rd_data_q;
            state_d     = S_EMIT2;
         end
         S_EMIT2: begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q;
            state_d     = S_PAIR_B;
         end
         S_PAIR_B: begin
            if (xfer) begin
               out_valid_d = 1'b1;
               out_data_d  = bus.in_data;
               if (col_plus2 >= {1'b0, width_q}) begin
                  row_end = 1'b1;
               end else begin
                  col_d   = col_plus2[CW-1:0];
                  state_d = S_PAIR_A;
               end
            end
         end
         S_DRAIN: begin
            if (xfer) begin
               if (col_q == width_q - CW'(1)) begin
                  col_d   = '0;
                  state_d = S_FIN;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // End of an odd row: advance by a row pair and pick the next phase.
      if (row_end) begin
         row_d = row_plus2;
         col_d = '0;
         if (row_plus2 == h_even) begin
            state_d = height_q[0] ? S_DRAIN : S_FIN;
         end else begin
            state_d = S_FILL;
         end
      end

      busy_d     = (state_d != S_IDLE);
      in_ready_d = (state_d == S_FILL) || (state_d == S_PAIR_A) ||
                   (state_d == S_PAIR_B) || (state_d == S_DRAIN);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         width_q     <= '0;
         height_q    <= '0;
         hold_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b0;
         pool_init_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         width_q     <= width_d;
         height_q    <= height_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
         pool_init_q <= pool_init_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Even-row buffer: single write port, registered read, contents not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         row_buf[col_q[AW-1:0]] <= bus.in_data;
      end
      rd_data_q <= row_buf[rd_addr];
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign pool_init     = pool_init_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Directed bench for pool_window_sequencer: feeds tiles, collects the window
// stream and compares it with hand-computed element orders.
module tb_pool_window_sequencer;

   localparam int CW = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] cfg_width = '0;
   logic [CW-1:0] cfg_height = '0;
   logic          pool_init;
   logic          busy;
   logic          done;

   pool_window_sequencer_if bus();

   pool_window_sequencer #(.MAX_W(64), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .bus        (bus),
      .pool_init  (pool_init),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   logic [7:0] pix[$];
   int cyc = 0;
   int done_cnt, init_cnt, clash_cnt, ready_cnt, valid_cnt;
   int init_cyc, first_valid_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (bus.out_valid) begin
            got.push_back(bus.out_data);
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
         if (done) done_cnt++;
         if (pool_init) begin
            init_cnt++;
            if (init_cyc < 0) init_cyc = cyc;
            if (bus.out_valid) clash_cnt++;
         end
         if (bus.in_ready) ready_cnt++;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_stats();
      got.delete();
      done_cnt = 0; init_cnt = 0; clash_cnt = 0; ready_cnt = 0; valid_cnt = 0;
      init_cyc = -1; first_valid_cyc = -1;
   endtask

   task automatic start_tile(input int w, input int h);
      start = 1'b1;
      cfg_width = CW'(w);
      cfg_height = CW'(h);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input bit gap);
      int guard;
      guard = 0;
      if (gap) begin
         bus.in_valid = 1'b0;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data = d;
      forever begin
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            break;
         end
         guard++;
         if (guard > 50) begin
            chk("ready_wait", {31'b0, bus.in_ready}, 1);
            bus.in_valid = 1'b0;
            break;
         end
      end
   endtask

   task automatic send_all(input bit gaps);
      foreach (pix[i]) send(pix[i], gaps ? ($urandom_range(0, 1) == 1) : 1'b0);
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while (done_cnt < 1 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      repeat (4) begin @(posedge clk); #1; end
      chk(tag, done_cnt, 1);
   endtask

   task automatic check_stream(input string tag);
      chk({tag, "_count"}, got.size(), exp_q.size());
      foreach (exp_q[i]) begin
         if (i < got.size()) chk($sformatf("%s_el%0d", tag, i), got[i], exp_q[i]);
      end
   endtask

   // Reference window order: TL, TR, BL, BR per window, floor pooling.
   task automatic build_expected(input int w, input int h);
      exp_q.delete();
      for (int r = 0; r + 1 < h; r += 2)
         for (int c = 0; c + 1 < w; c += 2) begin
            exp_q.push_back(pix[r*w + c]);
            exp_q.push_back(pix[r*w + c + 1]);
            exp_q.push_back(pix[(r+1)*w + c]);
            exp_q.push_back(pix[(r+1)*w + c + 1]);
         end
   endtask

   function automatic logic [7:0] max4(input int base);
      logic [7:0] m;
      m = got[base];
      for (int i = 1; i < 4; i++) if (got[base+i] > m) m = got[base+i];
      return m;
   endfunction

   logic [7:0] ref_run[$];

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
      chk("rst_out_data", {24'b0, bus.out_data}, 0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_pool_init", {31'b0, pool_init}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // W=4 H=2, rows 1..4 / 5..8
      clear_stats();
      pix = '{1, 2, 3, 4, 5, 6, 7, 8};
      exp_q = '{1, 2, 5, 6, 3, 4, 7, 8};
      start_tile(4, 2);
      chk("w4_busy", {31'b0, busy}, 1);
      chk("w4_init_now", {31'b0, pool_init}, 1);
      send_all(1'b0);
      wait_done("w4_done");
      check_stream("w4");
      chk("w4_init_cnt", init_cnt, 1);
      chk("w4_init_clash", clash_cnt, 0);
      chk("w4_init_lead", {31'b0, (init_cyc >= 0 && first_valid_cyc > init_cyc)}, 1);
      if (got.size() >= 8) begin
         chk("w4_max0", max4(0), 6);
         chk("w4_max1", max4(4), 8);
      end
      chk("w4_idle_busy", {31'b0, busy}, 0);

      // W=5 H=3, values 0..14
      clear_stats();
      pix.delete();
      for (int i = 0; i < 15; i++) pix.push_back(8'(i));
      exp_q = '{0, 1, 5, 6, 2, 3, 7, 8};
      start_tile(5, 3);
      send_all(1'b0);
      chk("w5_done_early", done_cnt, 0);
      wait_done("w5_done");
      check_stream("w5");
      chk("w5_ready_after", {31'b0, bus.in_ready}, 0);

      // W=8 H=4 without gaps, then with random gaps: identical stream
      clear_stats();
      pix.delete();
      for (int i = 0; i < 32; i++) pix.push_back(8'((i * 37 + 11) % 256));
      build_expected(8, 4);
      start_tile(8, 4);
      send_all(1'b0);
      wait_done("w8_done");
      check_stream("w8");
      ref_run = got;
      clear_stats();
      start_tile(8, 4);
      send_all(1'b1);
      wait_done("w8g_done");
      check_stream("w8g");
      chk("w8g_same_count", got.size(), ref_run.size());

      // Degenerate W=1 H=4
      clear_stats();
      start_tile(1, 4);
      chk("w1_done_next", {31'b0, done}, 1);
      repeat (5) begin @(posedge clk); #1; end
      chk("w1_done_cnt", done_cnt, 1);
      chk("w1_ready_cnt", ready_cnt, 0);
      chk("w1_valid_cnt", valid_cnt, 0);
      chk("w1_busy", {31'b0, busy}, 0);

      // Reset while in EMIT1, then a clean W=2 H=2 tile
      clear_stats();
      start_tile(4, 2);
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);   // now in EMIT0
      @(posedge clk); #1;                                // now in EMIT1
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 0);
      chk("mid_rst_out_data", {24'b0, bus.out_data}, 0);
      chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 0);
      chk("mid_rst_busy", {31'b0, busy}, 0);
      chk("mid_rst_done", {31'b0, done}, 0);
      chk("mid_rst_pool_init", {31'b0, pool_init}, 0);
      clear_stats();
      pix = '{9, 8, 7, 6};
      exp_q = '{9, 8, 7, 6};
      start_tile(2, 2);
      send_all(1'b0);
      wait_done("w2_done");
      check_stream("w2");

      // start pulsed while busy is ignored
      clear_stats();
      start_tile(4, 2);
      send(8'd1, 1'b0);
      send(8'd2, 1'b0);
      start = 1'b1;
      cfg_width = CW'(2);
      cfg_height = CW'(2);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 3; i <= 8; i++) send(8'(i), 1'b0);
      exp_q = '{1, 2, 5, 6, 3, 4, 7, 8};
      wait_done("busy_start_done");
      check_stream("busy_start");
      chk("busy_start_init_cnt", init_cnt, 1);
      chk("busy_start_idle", {31'b0, busy}, 0);
      chk("busy_start_ready", {31'b0, bus.in_ready}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
